// File: rtl/clkgen_sched.sv
// Virtual-clock generator with three delayed edge-strobe channels and a rising-edge halt counter.
// Optional feature: define CLKGEN_SCHED_OVERRUN_EN to implement the sticky overrun flag.
module clkgen_sched #(
  parameter int HP_W  = 8,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [HP_W-1:0]  half_period,
  input  logic [HP_W-1:0]  pos_dly,
  input  logic [HP_W-1:0]  neg_dly,
  input  logic [HP_W-1:0]  any_dly,
  input  logic [CYC_W-1:0] cyc_limit,
  output logic             vclk,
  output logic             pos_evt,
  output logic             neg_evt,
  output logic             any_evt,
  output logic [CYC_W-1:0] cyc_count,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic             w_start_acc, w_active, w_tick, w_rise_now, w_fall_now;
  logic             w_halt, w_term_now;
  logic [HP_W-1:0]  w_h_eff, w_cnt_cur, r_hcnt, r_hp;
  logic             r_vclk, w_vclk_cur, r_rise, r_fall, r_term_seen, r_pos_term;
  logic [CYC_W-1:0] r_cyc, w_cyc_cur, r_limit;
  logic [2:0]       w_trig, w_evt;
  logic [HP_W-1:0]  w_dly [3];

  // The start cycle behaves as if the half-period counter already held H,
  // so H=1 produces its first rising edge in the very next cycle.
  assign w_start_acc = start && (r_state != S_RUN);
  assign w_active    = w_start_acc || (r_state == S_RUN);
  assign w_h_eff     = (half_period == '0) ? HP_W'(1) : half_period;
  assign w_cnt_cur   = w_start_acc ? w_h_eff : r_hcnt;
  assign w_vclk_cur  = w_start_acc ? 1'b0 : r_vclk;
  assign w_cyc_cur   = w_start_acc ? '0 : r_cyc;
  assign w_tick      = w_active && (w_cnt_cur == HP_W'(1));
  // After the terminal rise no further rise is generated, so its strobe cannot be overwritten.
  assign w_rise_now  = w_tick && !w_vclk_cur && !(r_term_seen && !w_start_acc);
  assign w_fall_now  = w_tick && w_vclk_cur;

  assign w_term_now  = (r_limit != '0) && (r_cyc == r_limit);
  assign w_halt      = (r_state == S_RUN) && w_evt[0] && (w_trig[0] ? w_term_now : r_pos_term);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_next = S_RUN;
      S_RUN:          if (w_halt) w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vclk      <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_hcnt      <= '0;
      r_hp        <= '0;
      r_limit     <= '0;
      r_cyc       <= '0;
      r_term_seen <= 1'b0;
      r_pos_term  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_halt) begin
        r_vclk <= 1'b0;
      end else if (w_active) begin
        if (w_start_acc) begin
          r_hp    <= w_h_eff;
          r_limit <= cyc_limit;
        end
        r_hcnt <= w_tick ? (w_start_acc ? w_h_eff : r_hp) : (w_cnt_cur - HP_W'(1));
        r_vclk <= w_rise_now | (w_vclk_cur & ~w_fall_now);
        r_cyc  <= w_rise_now ? (w_cyc_cur + CYC_W'(1)) : w_cyc_cur;
        r_rise <= w_rise_now;
        r_fall <= w_fall_now;
      end
      if (w_start_acc)                r_term_seen <= 1'b0;
      else if (r_rise && w_term_now)  r_term_seen <= 1'b1;
      if (w_start_acc || w_halt)      r_pos_term  <= 1'b0;
      else if (w_trig[0])             r_pos_term  <= w_term_now;
    end
  end

  // Channel order: 0 = rising, 1 = falling, 2 = either edge.
  assign w_trig   = {r_rise | r_fall, r_fall, r_rise};
  assign w_dly[0] = pos_dly;
  assign w_dly[1] = neg_dly;
  assign w_dly[2] = any_dly;

`ifdef CLKGEN_SCHED_OVERRUN_EN
  logic [2:0] w_retrig;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic            r_pend;
      logic [HP_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || w_start_acc || w_halt) begin
          r_pend <= 1'b0;
          r_cnt  <= '0;
        end else if (w_trig[gi]) begin
          r_pend <= (w_dly[gi] != '0);
          r_cnt  <= w_dly[gi] - HP_W'(1);
        end else if (r_pend) begin
          if (r_cnt == '0) r_pend <= 1'b0;
          else             r_cnt  <= r_cnt - HP_W'(1);
        end
      end

      // A trigger overrides whatever was pending, including a strobe due this cycle.
      assign w_evt[gi] = w_trig[gi] ? (w_dly[gi] == '0) : (r_pend && (r_cnt == '0));
`ifdef CLKGEN_SCHED_OVERRUN_EN
      assign w_retrig[gi] = w_trig[gi] & r_pend;
`endif
    end
  endgenerate

`ifdef CLKGEN_SCHED_OVERRUN_EN
  logic r_overrun;
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) r_overrun <= 1'b0;
    else if (|w_retrig)     r_overrun <= 1'b1;
  end
  // Shown already in the retriggering edge cycle, then held by the register.
  assign overrun = r_overrun | (|w_retrig);
`else
  assign overrun = 1'b0;
`endif

  assign vclk      = r_vclk;
  assign pos_evt   = w_evt[0];
  assign neg_evt   = w_evt[1];
  assign any_evt   = w_evt[2];
  assign cyc_count = r_cyc;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_clkgen_sched.sv
// Directed bench for clkgen_sched: schedule, zero delays, overrun, mid-run reset, restart and wrap.
module tb_clkgen_sched;
  localparam int HP_W  = 8;
  localparam int CYC_W = 4;
`ifdef CLKGEN_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start;
  logic [HP_W-1:0]  half_period, pos_dly, neg_dly, any_dly;
  logic [CYC_W-1:0] cyc_limit;
  logic             vclk, pos_evt, neg_evt, any_evt, busy, done, overrun;
  logic [CYC_W-1:0] cyc_count;

  int checks = 0;
  int errors = 0;

  // Observation vector: vclk pos neg any busy done overrun cyc[3:0]
  logic [10:0] obs, exp_v;
  logic        e_v, e_p, e_n, e_a, e_b, e_d, e_o;
  logic [3:0]  e_c;
  assign obs = {vclk, pos_evt, neg_evt, any_evt, busy, done, overrun, cyc_count};

  clkgen_sched #(.HP_W(HP_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .half_period(half_period),
    .pos_dly(pos_dly), .neg_dly(neg_dly), .any_dly(any_dly), .cyc_limit(cyc_limit),
    .vclk(vclk), .pos_evt(pos_evt), .neg_evt(neg_evt), .any_evt(any_evt),
    .cyc_count(cyc_count), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int h, input int p, input int n, input int a, input int lim);
    half_period = HP_W'(h); pos_dly = HP_W'(p); neg_dly = HP_W'(n); any_dly = HP_W'(a);
    cyc_limit = CYC_W'(lim);
  endtask

  // Start is high in cycle 0; returns observing cycle 1.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    half_period = '0; pos_dly = '0; neg_dly = '0; any_dly = '0; cyc_limit = '0;
    do_reset();
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 11'b0);
    end
    tick(); tick();
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset_idle_hold got=%b want=%b", obs, 11'b0);
    end
    $display("test_reset complete");
  endtask

  task automatic test_basic();
    do_reset();
    set_cfg(10, 5, 7, 2, 5);
    launch();
    for (int c = 1; c <= 100; c++) begin
      e_v = (c >= 10) && (c <= 95) && (((c / 10) % 2) == 1);
      e_p = (c == 15) || (c == 35) || (c == 55) || (c == 75) || (c == 95);
      e_n = (c == 27) || (c == 47) || (c == 67) || (c == 87);
      e_a = (c >= 12) && (c <= 92) && ((c % 10) == 2);
      e_b = (c <= 95);
      e_d = (c >= 96);
      e_o = 1'b0;
      e_c = (c < 10) ? 4'd0 : (((c + 10) / 20 > 5) ? 4'd5 : 4'((c + 10) / 20));
      exp_v = {e_v, e_p, e_n, e_a, e_b, e_d, e_o, e_c};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL basic cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
      tick();
    end
    $display("test_basic complete");
  endtask

  task automatic test_zero_delay();
    do_reset();
    set_cfg(0, 0, 0, 0, 3);
    launch();
    for (int c = 1; c <= 8; c++) begin
      e_v = (c <= 5) && ((c % 2) == 1);
      e_p = (c == 1) || (c == 3) || (c == 5);
      e_n = (c == 2) || (c == 4);
      e_a = (c <= 5);
      e_b = (c <= 5);
      e_d = (c >= 6);
      e_o = 1'b0;
      e_c = (c <= 5) ? 4'((c + 1) / 2) : 4'd3;
      exp_v = {e_v, e_p, e_n, e_a, e_b, e_d, e_o, e_c};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL zero_delay cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
      tick();
    end
    $display("test_zero_delay complete");
  endtask

  task automatic test_overrun();
    do_reset();
    set_cfg(4, 9, 0, 0, 2);
    launch();
    for (int c = 1; c <= 24; c++) begin
      e_v = ((c >= 4) && (c <= 7)) || ((c >= 12) && (c <= 15));
      e_p = (c == 21);
      e_n = (c == 8) || (c == 16);
      e_a = (c == 4) || (c == 8) || (c == 12) || (c == 16);
      e_b = (c <= 21);
      e_d = (c >= 22);
      e_o = OVR_EN && (c >= 12);
      e_c = (c < 4) ? 4'd0 : ((c < 12) ? 4'd1 : 4'd2);
      exp_v = {e_v, e_p, e_n, e_a, e_b, e_d, e_o, e_c};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL overrun cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
      tick();
    end
    $display("test_overrun complete");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_cfg(10, 5, 7, 2, 5);
    launch();
    for (int c = 1; c < 14; c++) tick();
    checks++;
    if ({vclk, busy, cyc_count} !== {1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL pre_reset got=%b want=%b", {vclk, busy, cyc_count}, {1'b1, 1'b1, 4'd1});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid_run cycle=15 got=%b want=%b", obs, 11'b0);
    end
    for (int c = 16; c <= 30; c++) begin
      checks++;
      if (obs !== 11'b0) begin
        errors++;
        $display("FAIL after_reset cycle=%0d got=%b want=%b", c, obs, 11'b0);
      end
      tick();
    end
    $display("test_reset_mid_run complete");
  endtask

  task automatic test_restart_free_run();
    do_reset();
    set_cfg(10, 5, 7, 2, 5);
    launch();
    for (int c = 1; c < 30; c++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({vclk, busy, cyc_count} !== {1'b1, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL start_in_run_ignored got=%b want=%b", {vclk, busy, cyc_count}, {1'b1, 1'b1, 4'd2});
    end
    for (int c = 31; c < 96; c++) tick();
    checks++;
    if ({vclk, busy, done, cyc_count} !== {1'b0, 1'b0, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL done_before_restart got=%b want=%b", {vclk, busy, done, cyc_count}, {1'b0, 1'b0, 1'b1, 4'd5});
    end
    // Restart from DONE, H=2 free-running: rise k at offset 4k-2.
    set_cfg(2, 0, 0, 0, 0);
    launch();
    for (int off = 1; off <= 66; off++) begin
      e_v = (off >= 2) && (((off / 2) % 2) == 1);
      e_c = 4'(((off + 2) / 4) % 16);
      checks++;
      if ({vclk, busy, done, cyc_count} !== {e_v, 1'b1, 1'b0, e_c}) begin
        errors++;
        $display("FAIL restart_free_run offset=%0d got=%b want=%b", off,
                 {vclk, busy, done, cyc_count}, {e_v, 1'b1, 1'b0, e_c});
      end
      tick();
    end
    $display("test_restart_free_run complete");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    test_reset();
    test_basic();
    test_zero_delay();
    test_overrun();
    test_reset_mid_run();
    test_restart_free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
